// File: rtl/mem_arbiter_pkg.sv
// Shared state encoding and default bus widths for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_DATA_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GNT_I = 2'd1,
        ARB_GNT_D = 2'd2
    } arb_state_e;

endpackage

// File: rtl/arb_timer.sv
// Grant-state watchdog: clear on grant, count cycles without m_ack, flag the last allowed cycle.
module arb_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // TIMEOUT of 0 disables the abort path entirely.
    assign expired = (TIMEOUT > 0) && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one req/ack memory bus; data has priority,
// a starvation counter forces periodic fetch grants, and a watchdog aborts hung accesses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ARB_ADDR_W,
    parameter int DATA_W     = ARB_DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              d_err,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              hold_req
);

    localparam int SC_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic              m_req_q, m_req_d, m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              i_ack_q, i_ack_d, d_ack_q, d_ack_d;
    logic              i_err_q, i_err_d, d_err_q, d_err_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              pick_d, timer_clr, timer_inc, expired;

    arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .inc     (timer_inc),
        .expired (expired)
    );

    always_comb begin
        state_d   = state_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        starve_d  = starve_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        d_err_d   = 1'b0;
        timer_clr = 1'b0;
        timer_inc = 1'b0;
        pick_d    = d_req && !(i_req && (starve_q == SC_MAX));

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_d) begin
                    state_d   = ARB_GNT_D;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    timer_clr = 1'b1;
                    // Only data grants that bypass a waiting fetch count toward starvation.
                    if (!i_req)
                        starve_d = '0;
                    else if (starve_q != SC_MAX)
                        starve_d = starve_q + 1'b1;
                end else if (i_req) begin
                    state_d   = ARB_GNT_I;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    timer_clr = 1'b1;
                    starve_d  = '0;
                end
            end
            ARB_GNT_I, ARB_GNT_D: begin
                if (m_ack) begin
                    state_d = ARB_IDLE;
                    m_req_d = 1'b0;
                    if (state_q == ARB_GNT_I) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = m_rdata;
                    end else begin
                        d_ack_d = 1'b1;
                        if (!m_we_q)
                            d_rdata_d = m_rdata;
                    end
                end else if (expired) begin
                    state_d = ARB_IDLE;
                    m_req_d = 1'b0;
                    if (state_q == ARB_GNT_I) begin
                        i_ack_d   = 1'b1;
                        i_err_d   = 1'b1;
                        i_rdata_d = '0;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_err_d   = 1'b1;
                        d_rdata_d = '0;
                    end
                end else begin
                    timer_inc = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            i_err_q   <= i_err_d;
            d_err_q   <= d_err_d;
            starve_q  <= starve_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_we     = m_we_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign i_ack    = i_ack_q;
    assign d_ack    = d_ack_q;
    assign i_err    = i_err_q;
    assign d_err    = d_err_q;
    assign hold_req = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: directed timing cases plus a randomized two-port run
// checked against a requester-side memory model and starvation bookkeeping.
module tb_mem_arbiter;

    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we, m_ack;
    logic [15:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [15:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ack, i_err, d_ack, d_err, m_req, m_we, hold_req;

    int n_checks = 0;
    int n_fail   = 0;

    bit mem_auto = 1'b0;
    bit mem_rand = 1'b0;
    int mem_lat  = 0;
    int wait_cnt = 0;
    logic [15:0] bus_mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .hold_req(hold_req)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // Advance one cycle and sample 1 time unit after the edge; the auto memory answers here.
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_auto) begin
            if (m_ack) begin
                m_ack = 1'b0;
            end else if (m_req) begin
                if (wait_cnt >= mem_lat) begin
                    m_ack = 1'b1;
                    if (m_we) bus_mem[m_addr] = m_wdata;
                    else m_rdata = bus_mem.exists(m_addr) ? bus_mem[m_addr] : init_val(m_addr);
                    wait_cnt = 0;
                    if (mem_rand) mem_lat = $urandom_range(0, 3);
                end else begin
                    wait_cnt++;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_m_req: got %b want 0", m_req); end
        n_checks++; if (m_we !== 1'b0) begin n_fail++; $display("FAIL reset_m_we: got %b want 0", m_we); end
        n_checks++; if ({i_ack, d_ack, i_err, d_err} !== 4'b0) begin n_fail++; $display("FAIL reset_acks: got %b want 0000", {i_ack, d_ack, i_err, d_err}); end
        n_checks++; if (m_addr !== 16'h0 || m_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_m_bus: got %h/%h want 0/0", m_addr, m_wdata); end
        n_checks++; if (i_rdata !== 16'h0 || d_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", i_rdata, d_rdata); end
        n_checks++; if (hold_req !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", hold_req); end
        rst = 1'b0;
        // A stray memory ack while idle must do nothing.
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        n_checks++; if (i_ack !== 1'b0 || d_ack !== 1'b0 || m_req !== 1'b0) begin n_fail++; $display("FAIL idle_m_ack: got ack %b%b m_req %b want 000", i_ack, d_ack, m_req); end
        tick();
    endtask

    task automatic test_single_fetch();
        i_req = 1'b1; i_addr = 16'h0010;
        #1;
        n_checks++; if (hold_req !== 1'b1) begin n_fail++; $display("FAIL fetch_hold_rise: got %b want 1", hold_req); end
        tick();
        n_checks++; if (m_req !== 1'b1 || m_addr !== 16'h0010 || m_we !== 1'b0) begin n_fail++; $display("FAIL fetch_grant: got req %b addr %h we %b want 1 0010 0", m_req, m_addr, m_we); end
        m_ack = 1'b1; m_rdata = 16'h1234;
        tick();
        m_ack = 1'b0;
        n_checks++; if (i_ack !== 1'b1 || i_err !== 1'b0 || i_rdata !== 16'h1234) begin n_fail++; $display("FAIL fetch_ack: got ack %b err %b data %h want 1 0 1234", i_ack, i_err, i_rdata); end
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL fetch_m_req_drop: got %b want 0", m_req); end
        n_checks++; if (hold_req !== 1'b0) begin n_fail++; $display("FAIL fetch_hold_fall: got %b want 0", hold_req); end
        i_req = 1'b0;
        tick();
        n_checks++; if (i_ack !== 1'b0 || m_req !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse: got ack %b m_req %b want 0 0", i_ack, m_req); end
    endtask

    task automatic test_collision();
        logic [15:0] d_before;
        d_before = d_rdata;
        i_req = 1'b1; i_addr = 16'h0020;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
        tick();
        n_checks++; if (m_req !== 1'b1 || m_we !== 1'b1 || m_addr !== 16'h0200 || m_wdata !== 16'hBEEF) begin n_fail++; $display("FAIL coll_d_grant: got req %b we %b addr %h wd %h want 1 1 0200 beef", m_req, m_we, m_addr, m_wdata); end
        m_ack = 1'b1; m_rdata = 16'hDEAD;
        tick();
        m_ack = 1'b0;
        n_checks++; if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== d_before) begin n_fail++; $display("FAIL coll_d_ack: got ack %b err %b data %h want 1 0 %h", d_ack, d_err, d_rdata, d_before); end
        n_checks++; if (m_req !== 1'b0 || i_ack !== 1'b0) begin n_fail++; $display("FAIL coll_gap: got m_req %b i_ack %b want 0 0", m_req, i_ack); end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        n_checks++; if (m_req !== 1'b1 || m_addr !== 16'h0020 || m_we !== 1'b0) begin n_fail++; $display("FAIL coll_i_grant: got req %b addr %h we %b want 1 0020 0", m_req, m_addr, m_we); end
        m_ack = 1'b1; m_rdata = 16'h5555;
        tick();
        m_ack = 1'b0;
        n_checks++; if (i_ack !== 1'b1 || i_rdata !== 16'h5555 || d_rdata !== d_before) begin n_fail++; $display("FAIL coll_i_ack: got ack %b idata %h ddata %h want 1 5555 %h", i_ack, i_rdata, d_rdata, d_before); end
        i_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        bit prev_m_req;
        int ng;
        bit seq_i [10];
        mem_auto = 1'b1; mem_rand = 1'b0; mem_lat = 0; wait_cnt = 0;
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
        prev_m_req = 1'b0;
        ng = 0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            tick();
            if (m_req && !prev_m_req) begin
                seq_i[ng] = (m_addr == 16'h0040);
                ng++;
            end
            prev_m_req = m_req;
        end
        n_checks++; if (ng != 10) begin n_fail++; $display("FAIL starve_grants: got %0d grants want 10", ng); end
        for (int g = 0; g < ng; g++) begin
            n_checks++;
            if (seq_i[g] != ((g % (STARVE_MAX + 1)) == STARVE_MAX)) begin
                n_fail++; $display("FAIL starve_seq[%0d]: got %s want %s", g, seq_i[g] ? "I" : "D",
                                   ((g % (STARVE_MAX + 1)) == STARVE_MAX) ? "I" : "D");
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        tick(); tick(); tick();
        mem_auto = 1'b0; m_ack = 1'b0;
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL starve_drain: got m_req %b want 0", m_req); end
    endtask

    task automatic test_timeout();
        int hi;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0400;
        hi = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (m_req) hi++;
            else if (hi > 0) break;
        end
        n_checks++; if (hi != TIMEOUT) begin n_fail++; $display("FAIL timeout_len: got %0d cycles want %0d", hi, TIMEOUT); end
        n_checks++; if (d_ack !== 1'b1 || d_err !== 1'b1 || d_rdata !== 16'h0) begin n_fail++; $display("FAIL timeout_abort: got ack %b err %b data %h want 1 1 0000", d_ack, d_err, d_rdata); end
        d_req = 1'b0;
        tick();
        d_req = 1'b1; d_addr = 16'h0402;
        tick();
        n_checks++; if (m_req !== 1'b1 || m_addr !== 16'h0402) begin n_fail++; $display("FAIL timeout_next_grant: got req %b addr %h want 1 0402", m_req, m_addr); end
        m_ack = 1'b1; m_rdata = 16'h7777;
        tick();
        m_ack = 1'b0;
        n_checks++; if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 16'h7777) begin n_fail++; $display("FAIL timeout_next_ack: got ack %b err %b data %h want 1 0 7777", d_ack, d_err, d_rdata); end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_ack_at_expiry();
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0410;
        tick();
        for (int c = 1; c < TIMEOUT; c++) tick();
        n_checks++; if (m_req !== 1'b1 || d_ack !== 1'b0) begin n_fail++; $display("FAIL expiry_pre: got m_req %b d_ack %b want 1 0", m_req, d_ack); end
        m_ack = 1'b1; m_rdata = 16'h00AA;
        tick();
        m_ack = 1'b0;
        n_checks++; if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 16'h00AA) begin n_fail++; $display("FAIL expiry_ack: got ack %b err %b data %h want 1 0 00aa", d_ack, d_err, d_rdata); end
        d_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        i_req = 1'b1; i_addr = 16'h0050;
        tick();
        n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_grant: got %b want 1", m_req); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (m_req !== 1'b0 || i_ack !== 1'b0 || m_addr !== 16'h0) begin n_fail++; $display("FAIL rstmid_drop: got req %b ack %b addr %h want 0 0 0000", m_req, i_ack, m_addr); end
        tick();
        n_checks++; if (m_req !== 1'b1 || m_addr !== 16'h0050) begin n_fail++; $display("FAIL rstmid_regrant: got req %b addr %h want 1 0050", m_req, m_addr); end
        m_ack = 1'b1; m_rdata = 16'h4321;
        tick();
        m_ack = 1'b0;
        n_checks++; if (i_ack !== 1'b1 || i_rdata !== 16'h4321) begin n_fail++; $display("FAIL rstmid_ack: got ack %b data %h want 1 4321", i_ack, i_rdata); end
        i_req = 1'b0;
        tick();
    endtask

    // Random traffic on both ports; reads are checked against a memory kept from the
    // requesters' point of view, grants against data-priority/starvation rules.
    task automatic test_random();
        bit prev_m_req, issue, exp_hold;
        int sv_cnt;
        logic [15:0] exp;
        mem_auto = 1'b1; mem_rand = 1'b1; mem_lat = $urandom_range(0, 3); wait_cnt = 0;
        prev_m_req = 1'b0;
        sv_cnt = 0;
        for (int c = 0; c < 1600; c++) begin
            issue = (c < 1500);
            tick();
            if (m_req && !prev_m_req) begin
                n_checks++;
                if (m_addr[8]) begin
                    if (!d_req || m_addr !== d_addr || m_we !== d_we || (d_we && m_wdata !== d_wdata)) begin
                        n_fail++; $display("FAIL rnd_d_grant: got addr %h we %b wd %h want %h %b %h (pending %b)", m_addr, m_we, m_wdata, d_addr, d_we, d_wdata, d_req);
                    end
                    if (i_req) begin
                        n_checks++;
                        if (sv_cnt >= STARVE_MAX) begin n_fail++; $display("FAIL rnd_starve: got D grant after %0d bypasses want I", sv_cnt); end
                        sv_cnt++;
                    end else sv_cnt = 0;
                end else begin
                    if (!i_req || m_addr !== i_addr || m_we !== 1'b0) begin
                        n_fail++; $display("FAIL rnd_i_grant: got addr %h we %b want %h 0 (pending %b)", m_addr, m_we, i_addr, i_req);
                    end
                    n_checks++;
                    if (d_req && sv_cnt < STARVE_MAX) begin n_fail++; $display("FAIL rnd_priority: got I grant with D pending, bypasses %0d want D", sv_cnt); end
                    sv_cnt = 0;
                end
            end
            prev_m_req = m_req;
            exp_hold = (i_req && !i_ack) || (d_req && !d_ack);
            n_checks++; if (hold_req !== exp_hold) begin n_fail++; $display("FAIL rnd_hold: got %b want %b", hold_req, exp_hold); end
            if (i_ack) begin
                exp = ref_mem.exists(i_addr) ? ref_mem[i_addr] : init_val(i_addr);
                n_checks++;
                if (!i_req || i_err !== 1'b0 || i_rdata !== exp) begin n_fail++; $display("FAIL rnd_i_ack: got data %h err %b want %h 0 (pending %b)", i_rdata, i_err, exp, i_req); end
                i_req = 1'b0;
            end
            if (d_ack) begin
                n_checks++;
                if (!d_req || d_err !== 1'b0) begin n_fail++; $display("FAIL rnd_d_ack: got err %b pending %b want 0 1", d_err, d_req); end
                if (d_we) ref_mem[d_addr] = d_wdata;
                else begin
                    exp = ref_mem.exists(d_addr) ? ref_mem[d_addr] : init_val(d_addr);
                    n_checks++;
                    if (d_rdata !== exp) begin n_fail++; $display("FAIL rnd_d_read: got %h want %h at %h", d_rdata, exp, d_addr); end
                end
                d_req = 1'b0;
            end
            if (!i_req && issue && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = 16'($urandom_range(0, 15));
            end
            if (!d_req && issue && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                d_addr = 16'h0100 | 16'($urandom_range(0, 15)); d_wdata = 16'($urandom);
            end
            if (!issue && !i_req && !d_req) break;
        end
        n_checks++; if (i_req || d_req) begin n_fail++; $display("FAIL rnd_drain: got pending i %b d %b want 0 0", i_req, d_req); end
        tick(); tick();
        mem_auto = 1'b0; m_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        i_req = 1'b0; i_addr = 16'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0; d_wdata = 16'h0;
        m_ack = 1'b0; m_rdata = 16'h0;
        test_reset();
        test_single_fetch();
        test_collision();
        test_starvation();
        test_timeout();
        test_ack_at_expiry();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
